// File: rtl/seq_madd_ctrl_pkg.sv
// Shared types and defaults for the sequential multi-operand adder.
// State encoding plus the default operand width and operand count.
package madd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NOPS  = 8;

endpackage

// File: rtl/seq_madd_ctrl_if.sv
// Operand-in / sum-out handshake bundle; out_ovf exists only with MADD_OVF_EN.
// slave = the accumulator, master = the producer/consumer around it.
interface seq_madd_ctrl_if #(
  parameter int WIDTH = madd_pkg::DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
`ifdef MADD_OVF_EN
  logic             out_ovf;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
`ifdef MADD_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
`ifdef MADD_OVF_EN
    , input out_ovf
`endif
  );

endinterface

// File: rtl/seq_madd_ctrl_add.sv
// WIDTH-bit ripple-carry adder, carry-in fixed at 0; purely combinational.
// Carry-out is exposed so the controller can track overflow.
module madd_add #(
  parameter int WIDTH = madd_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_madd_ctrl.sv
// Sums NOPS operands in arrival order; result valid the cycle after the last accept.
// in_ready drops while a result waits for out_ready; MADD_OVF_EN adds out_ovf.
module seq_madd_ctrl
  import madd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NOPS  = DEF_NOPS
) (
  input  logic              clk,
  input  logic              rst,
  seq_madd_ctrl_if.slave    bus,
  output logic              busy
);

  localparam logic [7:0] LAST_CNT = 8'(NOPS - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             accept;

  madd_add #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (bus.in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept = bus.in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc    <= bus.in_data;
            busy_q <= 1'b1;
            if (NOPS == 1) begin
              // cnt stays 0 so it never exceeds NOPS-1
              cnt         <= '0;
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt   <= 8'd1;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            if (cnt == LAST_CNT) begin
              cnt         <= '0;
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MADD_OVF_EN
  logic ovf_q;

  // Sticky across the set; the first operand is a load, not an addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept && state == IDLE) begin
      ovf_q <= 1'b0;
    end else if (accept && state == ACCUM) begin
      ovf_q <= ovf_q | add_cout;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  logic unused_cout;
  assign unused_cout = add_cout;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign busy          = busy_q;

endmodule

// File: tb/tb_seq_madd_ctrl.sv
// Scoreboard bench: driver queues expected sums, monitor checks each delivered result.
// A second NOPS=1 instance covers the single-operand case.
module tb_seq_madd_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, busy1;

  seq_madd_ctrl_if #(.WIDTH(8)) ifc  ();
  seq_madd_ctrl_if #(.WIDTH(8)) ifc1 ();

  seq_madd_ctrl #(.WIDTH(8), .NOPS(N)) dut (.clk(clk), .rst(rst), .bus(ifc),  .busy(busy));
  seq_madd_ctrl #(.WIDTH(8), .NOPS(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1), .busy(busy1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliveries = 0;
  int ready_mode = 0;      // 0 always ready, 1 random, 2 manual
  bit ready_manual = 1'b1;
  logic [7:0] ops [N];
  logic [7:0] exp_q[$];
  bit         exp_ovf_q[$];
  int         deliv_cyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      ifc.out_ready = 1'b1;
      else if (ready_mode == 1) ifc.out_ready = 1'($urandom_range(0, 1));
      else                      ifc.out_ready = ready_manual;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result.
  initial begin
    logic [7:0] prev_sum;
    bit         holding;
    holding = 1'b0;
    prev_sum = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else if (ifc.out_valid) begin
        check("in_ready_low_in_done", int'(ifc.in_ready), 0);
        if (holding) check("out_sum_stable", int'(ifc.out_sum), int'(prev_sum));
        if (ifc.out_ready) begin
          holding = 1'b0;
          deliveries++;
          deliv_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            check("out_sum", int'(ifc.out_sum), int'(exp_q.pop_front()));
`ifdef MADD_OVF_EN
            check("out_ovf", int'(ifc.out_ovf), int'(exp_ovf_q.pop_front()));
`else
            void'(exp_ovf_q.pop_front());
`endif
          end
        end else begin
          holding = 1'b1;
          prev_sum = ifc.out_sum;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic send_op(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (ifc.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected value: the plain integer sum, wrapped; overflow iff the true sum exceeds 255.
  task automatic run_set(input int gap_after, input int gap_len, input bit rand_gaps);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(ops[i]);
    exp_q.push_back(8'(s));
    exp_ovf_q.push_back(s > 255);
    for (int i = 0; i < N; i++) begin
      if (rand_gaps) idle_cycles($urandom_range(0, 2));
      send_op(ops[i]);
      if (i == gap_after) idle_cycles(gap_len);
    end
    @(negedge clk);
    check("latency_out_valid", int'(ifc.out_valid), 1);
    check("busy_in_done", int'(busy), 1);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) ops[i] = 8'(i + 1);
  endtask

  task automatic wait_deliveries(input int target);
    for (int t = 0; t < 500 && deliveries < target; t++) @(posedge clk);
    check("delivery_count", deliveries, target);
  endtask

  initial begin
    int base;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    ifc1.in_valid = 1'b0;
    ifc1.in_data  = '0;
    ifc1.out_ready = 1'b1;

    // Operand offered during reset must be ignored.
    idle_cycles(2);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h77;
    idle_cycles(2);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(ifc.out_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(ifc.in_ready), 1);
    check("post_rst_out_valid", int'(ifc.out_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // Ramp 1..8, no gaps
    load_ramp();
    run_set(-1, 0, 1'b0);
    wait_deliveries(1);

    // All 0xFF
    for (int i = 0; i < N; i++) ops[i] = 8'hFF;
    run_set(-1, 0, 1'b0);
    wait_deliveries(2);

    // Gap after 4th operand, result held 5 cycles
    load_ramp();
    ready_manual = 1'b0;
    ready_mode = 2;
    idle_cycles(1);
    run_set(3, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_out_valid", int'(ifc.out_valid), 1);
      check("hold_out_sum", int'(ifc.out_sum), 8'h24);
    end
    ready_manual = 1'b1;
    wait_deliveries(3);
    ready_mode = 0;
    idle_cycles(1);

    // Reset mid-set discards partial sum
    send_op(8'd10);
    send_op(8'd20);
    send_op(8'd30);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_in_ready", int'(ifc.in_ready), 1);
    @(posedge clk);
    #1;
    load_ramp();
    run_set(-1, 0, 1'b0);
    wait_deliveries(4);

    // Back-to-back: ramp then eight 2s, 9 cycles apart
    base = deliv_cyc.size();
    load_ramp();
    run_set(-1, 0, 1'b0);
    for (int i = 0; i < N; i++) ops[i] = 8'd2;
    run_set(-1, 0, 1'b0);
    wait_deliveries(6);
    if (deliv_cyc.size() >= base + 2)
      check("b2b_spacing", deliv_cyc[base+1] - deliv_cyc[base], 9);
    else
      check("b2b_spacing_missing", deliv_cyc.size(), base + 2);

    // Random sets with random gaps and backpressure
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) ops[i] = 8'($urandom_range(0, 255));
      run_set(-1, 0, 1'b1);
    end
    wait_deliveries(12);
    ready_mode = 0;

    // NOPS=1 instance
    @(posedge clk);
    #1;
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = 8'h5A;
    @(negedge clk);
    check("n1_in_ready", int'(ifc1.in_ready), 1);
    @(posedge clk);
    #1;
    ifc1.in_valid = 1'b0;
    @(negedge clk);
    check("n1_out_valid", int'(ifc1.out_valid), 1);
    check("n1_out_sum", int'(ifc1.out_sum), 8'h5A);
    check("n1_in_ready_done", int'(ifc1.in_ready), 0);
`ifdef MADD_OVF_EN
    check("n1_out_ovf", int'(ifc1.out_ovf), 0);
`endif
    @(negedge clk);
    check("n1_back_idle", int'(ifc1.out_valid), 0);
    check("n1_busy_idle", int'(busy1), 0);

    idle_cycles(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
